// File: rtl/node_rec_pkg.sv
// node_rec_pkg: shared definitions for the CAN receive-event arbiter.
//   state_t    : arbiter FSM state encoding (IDLE / GRANT)
//   N_CHAN_DEF : default number of receive channels
//   OVF_CNT_W  : width of the optional overflow event counter
package node_rec_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam int N_CHAN_DEF = 32;
  localparam int OVF_CNT_W  = 16;

endpackage

// File: rtl/node_rec_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first set request
// bit at or after ptr_i, wrapping from N_CHAN-1 back to 0.
//   req_i   [N_CHAN-1:0] request vector
//   ptr_i   [IDX_W-1:0]  starting position of the search
//   idx_o   [IDX_W-1:0]  index of the selected request (0 when none)
//   found_o              at least one request bit is set
module rr_pick #(
  parameter int N_CHAN = 32,
  parameter int IDX_W  = $clog2(N_CHAN)
) (
  input  logic [N_CHAN-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              found_o
);

  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;
  logic             found_hi;
  logic             found_lo;

  // Two searches: lowest request at/after the pointer, and lowest request
  // overall. The second is the wrapped result when nothing lies above ptr.
  // Loops run high-to-low so the last hit is the lowest index.
  always_comb begin
    idx_hi   = '0;
    idx_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int j = N_CHAN - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        found_lo = 1'b1;
        idx_lo   = IDX_W'(j);
        if (IDX_W'(j) >= ptr_i) begin
          found_hi = 1'b1;
          idx_hi   = IDX_W'(j);
        end
      end
    end
  end

  assign found_o = found_lo;
  assign idx_o   = found_hi ? idx_hi : idx_lo;

endmodule

// File: rtl/node_rec_arbiter.sv
// node_rec_arbiter: latches rising-edge receive events from N_CHAN CAN node
// controllers and presents them one at a time, round-robin, on a
// valid/ready grant interface.
//
// Handshake: rec_valid/rec_idx are registered; once rec_valid is high they
// hold until the cycle rec_valid & rec_ready, which is the transfer. After
// each transfer rec_valid drops for one cycle. rec_ready is ignored while
// rec_valid is low.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   can_rec[N_CHAN]     per-channel receive-event level
//   chan_mask[N_CHAN]   1 = channel enabled
//   rec_valid, rec_idx  grant presented / granted channel index
//   rec_ready           consumer accepts the grant
//   pending[N_CHAN]     latched, unserviced events
//   ovf[N_CHAN]         sticky: event arrived while already pending
//   dbg_state           FSM state, for observation
//   ovf_clr             synchronous clear of all ovf bits
//   ovf_cnt[16]         only with NODE_REC_OVF_CNT_EN: saturating count of
//                       cycles in which any ovf bit sets
module node_rec_arbiter
  import node_rec_pkg::*;
#(
  parameter int N_CHAN = N_CHAN_DEF,
  parameter int IDX_W  = $clog2(N_CHAN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CHAN-1:0] can_rec,
  input  logic [N_CHAN-1:0] chan_mask,
  output logic              rec_valid,
  output logic [IDX_W-1:0]  rec_idx,
  input  logic              rec_ready,
  output logic [N_CHAN-1:0] pending,
  output logic [N_CHAN-1:0] ovf,
  output state_t            dbg_state,
  input  logic              ovf_clr
`ifdef NODE_REC_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_cnt
`endif
);

  localparam logic [N_CHAN-1:0] ONE_VEC = N_CHAN'(1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [N_CHAN-1:0] can_q;
  logic              armed_q;
  logic [N_CHAN-1:0] pend_q, pend_d;
  logic [N_CHAN-1:0] ovf_q, ovf_d;

  logic [N_CHAN-1:0] edge_ev;
  logic [N_CHAN-1:0] grant_vec;
  logic [N_CHAN-1:0] hs_vec;
  logic [N_CHAN-1:0] ovf_set;
  logic              hs;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;

  // Edge detection is suppressed for the first cycle after reset so a level
  // already high at reset release is not mistaken for a 0->1 transition.
  assign edge_ev   = armed_q ? (can_rec & ~can_q & chan_mask) : '0;
  assign hs        = (state_q == S_GRANT) && rec_ready;
  assign grant_vec = (state_q == S_GRANT) ? (ONE_VEC << idx_q) : '0;
  assign hs_vec    = hs ? grant_vec : '0;

  // Masking drops pending events except for the channel currently granted,
  // which must finish its handshake. A new event always wins over the clear.
  assign pend_d  = ((pend_q & ~hs_vec) & (chan_mask | grant_vec)) | edge_ev;
  // A re-event on the channel being handed over is simply re-latched.
  assign ovf_set = edge_ev & pend_q & ~hs_vec;
  assign ovf_d   = ovf_clr ? '0 : (ovf_q | ovf_set);

  rr_pick #(
    .N_CHAN (N_CHAN),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req_i   (pend_q),
    .ptr_i   (rr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_GRANT;
          idx_d   = pick_idx;
        end
      end
      S_GRANT: begin
        if (rec_ready) begin
          state_d = S_IDLE;
          rr_d    = (idx_q == IDX_W'(N_CHAN - 1)) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      can_q   <= '0;
      armed_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      can_q   <= can_rec;
      armed_q <= 1'b1;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rec_valid = (state_q == S_GRANT);
  assign rec_idx   = idx_q;
  assign pending   = pend_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

`ifdef NODE_REC_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr) begin
      cnt_d = '0;
    end else if ((|ovf_set) && (cnt_q != {OVF_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + OVF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_cnt = cnt_q;
`endif

endmodule

// File: doc/node_rec_arbiter.md
NODE_REC_ARBITER -- requirements
Module: node_rec_arbiter

Interface
REQ-001 Parameter N_CHAN, default 32, number of CAN receive channels (2..64).
REQ-002 Parameter IDX_W, default $clog2(N_CHAN), width of the channel index.
REQ-003 Port clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset, asynchronous and active-low.
REQ-005 Port can_rec, input, N_CHAN, per-channel receive-event level from the CAN node controllers.
REQ-006 Port chan_mask, input, N_CHAN, 1 = channel enabled; 0 = events ignored.
REQ-007 Port rec_valid, output, 1, a granted channel is presented.
REQ-008 Port rec_idx, output, IDX_W, index of the granted channel, valid when rec_valid=1.
REQ-009 Port rec_ready, input, 1, consumer accepts the grant.
REQ-010 Port pending, output, N_CHAN, registered vector of latched, not yet serviced events.
REQ-011 Port ovf, output, N_CHAN, sticky flag: a new event arrived while the same channel was already pending.
REQ-012 Port ovf_clr, input, 1, synchronous clear of all ovf bits.

Function
REQ-013 Registered rising-edge detect per channel; an event is a 0->1 transition of can_rec[i] with chan_mask[i]=1.
REQ-014 An event sets pending[i] one cycle after the edge is sampled.
REQ-015 FSM states IDLE and GRANT; IDLE->GRANT when any pending bit is set, GRANT->IDLE on rec_valid & rec_ready.
REQ-016 On entering GRANT, the arbiter selects the first pending channel at or after rr_ptr, wrapping N_CHAN-1 -> 0. rec_idx and rec_valid are registered.
REQ-017 Latency: edge sampled in cycle t -> pending in t+1 -> rec_valid in t+2 (idle arbiter).
REQ-018 rec_idx and rec_valid hold stable while rec_valid=1 and rec_ready=0.
REQ-019 On handshake, pending[rec_idx] clears and rr_ptr becomes rec_idx+1 modulo N_CHAN.
REQ-020 Back-to-back: with further pending bits, rec_valid drops for exactly one cycle (IDLE) before the next grant.
REQ-021 If a new event on rec_idx coincides with its handshake, pending stays set (set wins) and ovf is not raised.
REQ-022 If an event arrives on a channel whose pending bit is already set (not in the handshake cycle), ovf[i] sets. ovf_clr takes priority over a same-cycle set.
REQ-023 Clearing chan_mask[i] clears pending[i] next cycle unless i is currently granted; a granted channel completes its handshake.
REQ-024 rec_ready while rec_valid=0 has no effect.

Reset
REQ-025 Reset (rst=0) asynchronously clears pending, ovf, edge registers, rr_ptr=0, state=IDLE, rec_valid=0, rec_idx=0.
REQ-026 A can_rec level already high at reset release is not an event; only a later 0->1 transition counts.
REQ-027 Reset during GRANT drops the grant without a handshake; the event is lost.

Configuration
REQ-028 Macro NODE_REC_OVF_CNT_EN: when defined, adds output ovf_cnt (16 bits), saturating at 16'hFFFF, incremented once per cycle in which any ovf bit sets, cleared by reset and ovf_clr. When undefined, the port and its logic do not exist; ovf flags are unaffected.

Structure
REQ-029 Shared package node_rec_pkg holds the FSM state typedef, the default N_CHAN and the ovf_cnt width constant.
REQ-030 A sub-module rr_pick (combinational priority search from a rotating pointer, N_CHAN-wide request, IDX_W index + found flag) is instantiated once.

Verification
REQ-031 Reset, then a pulse on can_rec[0], rec_ready=1 -> rec_valid at edge+2 with rec_idx=0, then pending=0.
REQ-032 Simultaneous edges on channels 1, 30 and 31, rec_ready=1 -> grants in order 1, 30, 31, each separated by one idle cycle.
REQ-033 rr_ptr=31 after servicing 30, pending {0,31} -> grant 31, then 0 (wrap).
REQ-034 rec_ready=0 for 5 cycles while granting channel 5 -> rec_idx=5 held stable; a second edge on ch5 sets ovf[5]; ovf_clr clears it.
REQ-035 chan_mask[2]=0 and edge on ch2 -> no pending, no grant; re-enable, new edge -> grant 2.
REQ-036 With NODE_REC_OVF_CNT_EN defined, three overflow events -> ovf_cnt=3; ovf_clr -> 0.
